gemm_output_collector: RTL and testbench

GEMM_OUTPUT_COLLECTOR -- requirements
Module: gemm_output_collector

---
 rtl/GEMM_pkg.sv | 19 +
 rtl/gemm_row_fifo.sv | 65 ++++++
 rtl/gemm_output_collector.sv | 147 ++++++++++++++
 tb/tb_gemm_output_collector.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/GEMM_pkg.sv
// GEMM_pkg -- shared GEMM types.
//   command_t          : command currently driven to the GEMM array.
//   collector_state_t  : state of gemm_output_collector's job FSM.
package GEMM_pkg;

   typedef enum logic [1:0] {
      CMD_NONE          = 2'd0,
      CMD_WRITE_WEIGHTS = 2'd1,
      CMD_STREAM        = 2'd2
   } command_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } collector_state_t;

endpackage

// File: rtl/gemm_row_fifo.sv
// gemm_row_fifo -- first-word fall-through row buffer.
//   clk, resetn : clock, synchronous active-low reset (clears pointers/occupancy)
//   push        : write wr_data; accepted when not full, or when full and a pop
//                 happens in the same cycle
//   pop         : drop head word (ignored when empty)
//   rd_data     : head word, valid whenever empty==0
//   full, empty : occupancy flags
module gemm_row_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // Explicit wrap so non-power-of-two depths also work.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is data only; validity comes from the reset pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/gemm_output_collector.sv
// gemm_output_collector -- captures GEMM output rows for one job and presents
// them through a FWFT buffer with valid/ready handshake.
//   clk, resetn         : clock, synchronous active-low reset
//   start, num_rows     : job start pulse and rows expected (sampled on start)
//   cmd, output_valid,
//   activation_outputs  : GEMM command and output row
//   row_data, row_index,
//   row_valid, row_ready: head row, its job row number, handshake
//   busy, done          : job status (COLLECT/DRAIN, DONE)
//   overflow, stray_row : sticky error flags
//   row_checksum        : unsigned element sum of the head row, only when
//                         GEMM_COLLECT_CHECKSUM_EN is defined
module gemm_output_collector
   import GEMM_pkg::*;
#(
   parameter int SA_SIZE                = 4,
   parameter int WEIGHT_ACTIVATION_SIZE = 8,
   parameter int FIFO_DEPTH             = 4,
   parameter int MAX_ROWS               = 16
) (
   input  logic                                      clk,
   input  logic                                      resetn,
   input  logic                                      start,
   input  logic [$clog2(MAX_ROWS+1)-1:0]             num_rows,
   input  command_t                                  cmd,
   input  logic                                      output_valid,
   input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] activation_outputs,
   output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] row_data,
   output logic                                      row_valid,
   input  logic                                      row_ready,
   output logic [$clog2(MAX_ROWS)-1:0]               row_index,
`ifdef GEMM_COLLECT_CHECKSUM_EN
   output logic [WEIGHT_ACTIVATION_SIZE+$clog2(SA_SIZE)-1:0] row_checksum,
`endif
   output logic                                      busy,
   output logic                                      done,
   output logic                                      overflow,
   output logic                                      stray_row
);

   localparam int W      = WEIGHT_ACTIVATION_SIZE;
   localparam int ROW_W  = SA_SIZE * W;
   localparam int IDX_W  = $clog2(MAX_ROWS);
   localparam int CNT_W  = $clog2(MAX_ROWS + 1);
`ifdef GEMM_COLLECT_CHECKSUM_EN
   localparam int CSUM_W = W + $clog2(SA_SIZE);
   localparam int FIFO_W = CSUM_W + IDX_W + ROW_W;
`else
   localparam int FIFO_W = IDX_W + ROW_W;
`endif

   collector_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] n_q;
   logic             capture;
   logic             pop;
   logic             start_ok;
   logic             stray_evt;
   logic             fifo_full;
   logic             fifo_empty;
   logic [FIFO_W-1:0] fifo_wr;
   logic [FIFO_W-1:0] fifo_rd;

`ifdef GEMM_COLLECT_CHECKSUM_EN
   function automatic logic [CSUM_W-1:0] row_sum(input logic [ROW_W-1:0] r);
      logic [CSUM_W-1:0] s;
      s = '0;
      for (int i = 0; i < SA_SIZE; i++) s = s + CSUM_W'(r[i*W +: W]);
      return s;
   endfunction

   assign fifo_wr = {row_sum(activation_outputs), cnt[IDX_W-1:0], activation_outputs};
`else
   assign fifo_wr = {cnt[IDX_W-1:0], activation_outputs};
`endif

   assign capture   = (state == COLLECT) && output_valid && (cmd == CMD_STREAM);
   assign stray_evt = (state != COLLECT) && output_valid && (cmd == CMD_STREAM);
   assign start_ok  = start && ((state == IDLE) || (state == DONE));
   assign row_valid = !fifo_empty;
   assign pop       = row_valid && row_ready;
   assign cnt_inc   = cnt + CNT_W'(1);

   // The FIFO itself accepts a push into a full buffer only alongside a pop.
   gemm_row_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (capture),
      .wr_data (fifo_wr),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = (num_rows != '0) ? COLLECT : DONE;
         COLLECT:    if (capture && (cnt_inc == n_q)) state_nxt = DRAIN;
         DRAIN:      if (fifo_empty) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Row counter advances on every capture, including dropped rows.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt       <= '0;
         n_q       <= '0;
         overflow  <= 1'b0;
         stray_row <= 1'b0;
      end else begin
         if (start_ok && (num_rows != '0)) begin
            n_q      <= num_rows;
            cnt      <= '0;
            overflow <= 1'b0;
         end else if (capture) begin
            cnt <= cnt_inc;
            if (fifo_full && !pop) overflow <= 1'b1;
         end
         // A stray row seen in the same cycle as start still gets flagged.
         if (stray_evt)                         stray_row <= 1'b1;
         else if (start_ok && (num_rows != '0)) stray_row <= 1'b0;
      end
   end

   // Storage is unreset, so outputs are masked to zero while nothing is held.
   assign row_data  = row_valid ? fifo_rd[ROW_W-1:0] : '0;
   assign row_index = row_valid ? fifo_rd[ROW_W +: IDX_W] : '0;
`ifdef GEMM_COLLECT_CHECKSUM_EN
   assign row_checksum = row_valid ? fifo_rd[ROW_W+IDX_W +: CSUM_W] : '0;
`endif

   assign busy = (state == COLLECT) || (state == DRAIN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_gemm_output_collector.sv
module tb_gemm_output_collector;
   import GEMM_pkg::*;

   localparam int SA  = 4;
   localparam int W   = 8;
   localparam int FD  = 4;
   localparam int MR  = 16;
   localparam int NRW = $clog2(MR + 1);
   localparam int IW  = $clog2(MR);
   localparam int RW  = SA * W;
   localparam int CW  = W + $clog2(SA);

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           start = 1'b0;
   logic [NRW-1:0] num_rows = '0;
   command_t       cmd = CMD_NONE;
   logic           output_valid = 1'b0;
   logic [RW-1:0]  activation_outputs = '0;
   logic [RW-1:0]  row_data;
   logic           row_valid;
   logic           row_ready = 1'b0;
   logic [IW-1:0]  row_index;
   logic           busy, done, overflow, stray_row;
`ifdef GEMM_COLLECT_CHECKSUM_EN
   logic [CW-1:0]  row_checksum;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gemm_output_collector #(
      .SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .FIFO_DEPTH(FD), .MAX_ROWS(MR)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .num_rows(num_rows), .cmd(cmd),
      .output_valid(output_valid), .activation_outputs(activation_outputs),
      .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
      .row_index(row_index),
`ifdef GEMM_COLLECT_CHECKSUM_EN
      .row_checksum(row_checksum),
`endif
      .busy(busy), .done(done), .overflow(overflow), .stray_row(stray_row)
   );

   // ---------------- reference model: job status + queue of held rows
   typedef struct { logic [RW-1:0] d; int idx; } row_t;
   localparam int M_IDLE = 0, M_COLLECT = 1, M_DRAIN = 2, M_DONE = 3;
   row_t mq[$];
   row_t obs[$];
   int   m_st = M_IDLE, m_cnt = 0, m_n = 0;
   bit   m_ovf = 0, m_stray = 0, m_rst = 1;

   function automatic logic [CW-1:0] elem_sum(input logic [RW-1:0] r);
      int s = 0;
      for (int i = 0; i < SA; i++) s += int'(r[i*W +: W]);
      return CW'(s);
   endfunction

   task automatic model_step();
      bit   was_empty, pop, stray;
      row_t r;
      if (!resetn) begin
         mq.delete(); m_st = M_IDLE; m_cnt = 0; m_n = 0; m_ovf = 0; m_stray = 0; m_rst = 1;
         return;
      end
      m_rst = 0;
      was_empty = (mq.size() == 0);
      pop   = !was_empty && row_ready;
      stray = output_valid && cmd == CMD_STREAM && m_st != M_COLLECT;
      if (pop) void'(mq.pop_front());
      case (m_st)
         M_IDLE, M_DONE:
            if (start) begin
               if (num_rows != 0) begin
                  m_n = int'(num_rows); m_cnt = 0; m_ovf = 0; m_stray = 0; m_st = M_COLLECT;
               end else m_st = M_DONE;
            end
         M_COLLECT:
            if (output_valid && cmd == CMD_STREAM) begin
               if (mq.size() < FD) begin
                  r.d = activation_outputs; r.idx = m_cnt; mq.push_back(r);
               end else m_ovf = 1;
               m_cnt++;
               if (m_cnt == m_n) m_st = M_DRAIN;
            end
         default:
            if (was_empty) m_st = M_DONE;
      endcase
      if (stray) m_stray = 1;
   endtask

   task automatic check_model();
      bit            ev, bad;
      logic [RW-1:0] ed;
      int            ei;
      ev = (mq.size() > 0);
      ed = ev ? mq[0].d : '0;
      ei = ev ? mq[0].idx : 0;
      bad = (row_valid !== ev) || (busy !== (m_st == M_COLLECT || m_st == M_DRAIN)) ||
            (done !== (m_st == M_DONE)) || (overflow !== m_ovf) || (stray_row !== m_stray);
      if (ev || m_rst) bad = bad || (row_data !== ed) || (row_index !== IW'(ei));
`ifdef GEMM_COLLECT_CHECKSUM_EN
      if (ev) bad = bad || (row_checksum !== elem_sum(ed));
`endif
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL model t=%0t: got v=%0b d=%h i=%0d busy=%0b done=%0b ovf=%0b stray=%0b; want v=%0b d=%h i=%0d st=%0d ovf=%0b stray=%0b",
                  $time, row_valid, row_data, row_index, busy, done, overflow, stray_row,
                  ev, ed, ei, m_st, m_ovf, m_stray);
      end
   endtask

   task automatic cyc(input bit rn, input bit st, input int nr, input command_t c,
                      input bit ov, input logic [RW-1:0] d, input bit rdy);
      row_t o;
      resetn = rn; start = st; num_rows = NRW'(nr); cmd = c;
      output_valid = ov; activation_outputs = d; row_ready = rdy;
      if (rn && row_valid && row_ready) begin
         o.d = row_data; o.idx = int'(row_index); obs.push_back(o);
      end
      model_step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic reset_cyc();           cyc(0, 0, 0, CMD_NONE, 0, '0, 0); endtask
   task automatic start_cyc(input int n); cyc(1, 1, n, CMD_NONE, 0, '0, 0); endtask
   task automatic idle_cyc(input bit rdy); cyc(1, 0, 0, CMD_NONE, 0, '0, rdy); endtask
   task automatic row_cyc(input logic [RW-1:0] d, input bit rdy);
      cyc(1, 0, 0, CMD_STREAM, 1, d, rdy);
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   // ---------------- directed vector table
   typedef struct {
      bit rn; bit st; int nr; command_t c; bit ov; logic [RW-1:0] d; bit rdy;
      bit ev; logic [RW-1:0] ed; int ei; bit eb; bit edn; bit eo; bit es;
   } vec_t;
   vec_t tbl[9];

   initial begin
      logic [RW-1:0] a1, a2;
      logic [RW-1:0] din [5];
      a1 = 32'h1122_3344;
      a2 = 32'hA5B6_C7D8;
      //            rn st nr cmd          ov d   rdy  ev ed  ei eb edn eo es
      tbl[0] = '{0, 0, 0, CMD_NONE,   0, '0, 0,   0, '0, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 0, 0, CMD_STREAM, 1, a1, 0,   0, '0, 0, 0, 0, 0, 1};
      tbl[2] = '{1, 1, 2, CMD_NONE,   0, '0, 0,   0, '0, 0, 1, 0, 0, 0};
      tbl[3] = '{1, 0, 0, CMD_NONE,   1, a2, 0,   0, '0, 0, 1, 0, 0, 0};
      tbl[4] = '{1, 0, 0, CMD_STREAM, 1, a1, 0,   1, a1, 0, 1, 0, 0, 0};
      tbl[5] = '{1, 0, 0, CMD_STREAM, 1, a2, 1,   1, a2, 1, 1, 0, 0, 0};
      tbl[6] = '{1, 0, 0, CMD_NONE,   0, '0, 1,   0, '0, 0, 1, 0, 0, 0};
      tbl[7] = '{1, 0, 0, CMD_NONE,   0, '0, 1,   0, '0, 0, 0, 1, 0, 0};
      tbl[8] = '{1, 1, 0, CMD_STREAM, 1, a1, 1,   0, '0, 0, 0, 1, 0, 1};

      for (int i = 0; i < 9; i++) begin
         bit bad;
         resetn = tbl[i].rn; start = tbl[i].st; num_rows = NRW'(tbl[i].nr);
         cmd = tbl[i].c; output_valid = tbl[i].ov; activation_outputs = tbl[i].d;
         row_ready = tbl[i].rdy;
         @(posedge clk);
         #1;
         bad = (row_valid !== tbl[i].ev) || (busy !== tbl[i].eb) || (done !== tbl[i].edn) ||
               (overflow !== tbl[i].eo) || (stray_row !== tbl[i].es);
         if (tbl[i].ev || !tbl[i].rn)
            bad = bad || (row_data !== tbl[i].ed) || (row_index !== IW'(tbl[i].ei));
         checks++;
         if (bad) begin
            failures++;
            $display("FAIL vec%0d: got v=%0b d=%h i=%0d busy=%0b done=%0b ovf=%0b stray=%0b; want v=%0b d=%h i=%0d busy=%0b done=%0b ovf=%0b stray=%0b",
                     i, row_valid, row_data, row_index, busy, done, overflow, stray_row,
                     tbl[i].ev, tbl[i].ed, tbl[i].ei, tbl[i].eb, tbl[i].edn, tbl[i].eo, tbl[i].es);
         end
      end

      // ---- five rows streamed with consumer always ready
      reset_cyc();
      obs.delete();
      start_cyc(5);
      for (int i = 0; i < 5; i++) begin
         din[i] = $urandom;
         row_cyc(din[i], 1);
      end
      for (int k = 0; k < 10 && !done; k++) idle_cyc(1);
      chk("s1_pops", obs.size(), 5);
      for (int i = 0; i < 5 && i < obs.size(); i++) begin
         chk($sformatf("s1_idx%0d", i), obs[i].idx, i);
         chk($sformatf("s1_dat%0d", i), obs[i].d, din[i]);
      end
      chk("s1_done", done, 1);
      chk("s1_ovf", overflow, 0);

      // ---- five rows into a four-deep buffer with consumer stalled
      reset_cyc();
      obs.delete();
      start_cyc(5);
      for (int i = 0; i < 5; i++) row_cyc($urandom, 0);
      chk("s2_ovf", overflow, 1);
      chk("s2_valid", row_valid, 1);
      chk("s2_head", row_index, 0);
      for (int k = 0; k < 20 && !done; k++) idle_cyc(1);
      chk("s2_pops", obs.size(), 4);
      for (int i = 0; i < 4 && i < obs.size(); i++)
         chk($sformatf("s2_idx%0d", i), obs[i].idx, i);
      chk("s2_done", done, 1);

      // ---- reset in the middle of a job, then a one-row job
      start_cyc(5);
      row_cyc($urandom, 0);
      row_cyc($urandom, 0);
      reset_cyc();
      chk("s3_rst", {row_valid, busy, done, overflow, stray_row}, 5'b0);
      chk("s3_rst_idx", row_index, 0);
      chk("s3_rst_dat", row_data, 0);
      idle_cyc(0);
      chk("s3_nohold", row_valid, 0);
      obs.delete();
      start_cyc(1);
      din[0] = $urandom;
      row_cyc(din[0], 0);
      chk("s3_valid", row_valid, 1);
      chk("s3_idx", row_index, 0);
      for (int k = 0; k < 10 && !done; k++) idle_cyc(1);
      chk("s3_done", done, 1);
      chk("s3_pops", obs.size(), 1);
      if (obs.size() > 0) chk("s3_dat", obs[0].d, din[0]);

`ifdef GEMM_COLLECT_CHECKSUM_EN
      start_cyc(1);
      row_cyc({8'd250, 8'd3, 8'd2, 8'd1}, 0);
      chk("csum", row_checksum, 256);
      for (int k = 0; k < 10 && !done; k++) idle_cyc(1);
`endif

      // ---- randomized traffic against the model
      reset_cyc();
      for (int n = 0; n < 3000; n++) begin
         bit       rn, st, ov, rdy;
         int       nr;
         command_t c;
         rn  = ($urandom_range(0, 79) != 0);
         st  = ($urandom_range(0, 9) == 0);
         nr  = ($urandom_range(0, 7) == 0) ? MR : $urandom_range(0, 9);
         c   = command_t'($urandom_range(0, 2));
         ov  = ($urandom_range(0, 9) < 6);
         rdy = ($urandom_range(0, 9) < 5);
         cyc(rn, st, nr, c, ov, $urandom, rdy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
